envelope_sequencer: RTL and testbench

ENVELOPE_SEQUENCER -- requirements
Module: envelope_sequencer

---
 rtl/envelope_sequencer.sv | 130 +++++++++++++
 tb/tb_envelope_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/envelope_sequencer.sv
// Per-strobe envelope step fetcher.
// Reads a step count and then one amplitude nibble from a word-addressed ROM with a fixed read latency.
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | waiting for a frame strobe
// LEN_ADDR | drive length-table address
// LEN_WAIT | hold length address until ROM data is valid
// LEN_READ | capture final-step index L
// ENV_ADDR | drive envelope-table address
// ENV_WAIT | hold envelope address until ROM data is valid
// ENV_READ | capture amplitude nibble
// OUTPUT   | one-cycle o_valid pulse, advance step index
module envelope_sequencer #(
  parameter logic [7:0] BASE_ADDRESS = 8'h00,
  parameter int         ROM_LATENCY  = 1,
  parameter bit         LOOP_ENABLE  = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load_instrument,
  input  logic [3:0]  i_instrument,
  input  logic        i_note_on,
  input  logic        i_strobe,
  output logic        o_valid,
  output logic [3:0]  o_amplitude,
  output logic        o_done,
  output logic        o_busy,
  output logic [7:0]  o_rom_addr,
  input  logic [15:0] i_rom_data
);

  typedef enum logic [2:0] {
    IDLE, LEN_ADDR, LEN_WAIT, LEN_READ, ENV_ADDR, ENV_WAIT, ENV_READ, OUTPUT
  } state_t;

  localparam bit         HAS_WAIT  = (ROM_LATENCY > 1);
  localparam logic [1:0] WAIT_INIT = HAS_WAIT ? 2'(ROM_LATENCY - 2) : 2'd0;

  state_t     state, next_state;
  logic [3:0] inst_q, work_inst, len_q, index_q, work_idx, amp_q;
  logic [1:0] wait_cnt;
  logic       done_q, note_pend;
  logic [7:0] len_addr, env_addr;
  logic       last_step, note_block;

  assign len_addr   = BASE_ADDRESS + {6'd0, work_inst[3:2]};
  assign env_addr   = BASE_ADDRESS + 8'd4 + {2'b00, work_inst, work_idx[3:2]};
  assign last_step  = (work_idx >= len_q);
  // A note-on seen during the fetch must not be overwritten by this step's index update.
  assign note_block = i_note_on | note_pend;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      inst_q    <= 4'd0;
      work_inst <= 4'd0;
      len_q     <= 4'd0;
      index_q   <= 4'd0;
      work_idx  <= 4'd0;
      amp_q     <= 4'd0;
      wait_cnt  <= 2'd0;
      done_q    <= 1'b0;
      note_pend <= 1'b0;
    end else begin
      state <= next_state;
      if (i_load_instrument) inst_q <= i_instrument;
      if (state == IDLE && i_strobe) begin
        work_inst <= inst_q;
        work_idx  <= i_note_on ? 4'd0 : index_q;
      end
      if (state == LEN_ADDR || state == ENV_ADDR) wait_cnt <= WAIT_INIT;
      else if (state == LEN_WAIT || state == ENV_WAIT) wait_cnt <= wait_cnt - 2'd1;
      if (state == LEN_READ) len_q <= i_rom_data[{work_inst[1:0], 2'b00} +: 4];
      if (state == ENV_READ) amp_q <= i_rom_data[{work_idx[1:0], 2'b00} +: 4];
      if (state == OUTPUT && !note_block) begin
        if (!last_step)       index_q <= work_idx + 4'd1;
        else if (LOOP_ENABLE) index_q <= 4'd0;
        else begin
          index_q <= work_idx;
          done_q  <= 1'b1;
        end
      end
      if (state == OUTPUT)                      note_pend <= 1'b0;
      else if (i_note_on && state != IDLE)      note_pend <= 1'b1;
      if (i_note_on) begin
        index_q <= 4'd0;
        done_q  <= 1'b0;
      end
    end
  end

  always_comb begin
    next_state = state;
    o_valid    = 1'b0;
    o_rom_addr = 8'd0;
    case (state)
      IDLE:     if (i_strobe) next_state = LEN_ADDR;
      LEN_ADDR: begin
        o_rom_addr = len_addr;
        next_state = HAS_WAIT ? LEN_WAIT : LEN_READ;
      end
      LEN_WAIT: begin
        o_rom_addr = len_addr;
        if (wait_cnt == 2'd0) next_state = LEN_READ;
      end
      LEN_READ: next_state = ENV_ADDR;
      ENV_ADDR: begin
        o_rom_addr = env_addr;
        next_state = HAS_WAIT ? ENV_WAIT : ENV_READ;
      end
      ENV_WAIT: begin
        o_rom_addr = env_addr;
        if (wait_cnt == 2'd0) next_state = ENV_READ;
      end
      ENV_READ: next_state = OUTPUT;
      OUTPUT: begin
        o_valid    = 1'b1;
        next_state = IDLE;
      end
      default:  next_state = IDLE;
    endcase
  end

  assign o_amplitude = amp_q;
  assign o_busy      = (state != IDLE);
  // Done shows with the pulse that emits the final step, then persists in done_q.
  assign o_done      = done_q | (state == OUTPUT && !note_block && last_step && !LOOP_ENABLE);

endmodule

// File: tb/tb_envelope_sequencer.sv
// Bench for envelope_sequencer: two latency-1 instances (hold / loop) and one latency-3 instance.
// Expected amplitude/done records are queued at each strobe and popped on o_valid.
module tb_envelope_sequencer;

  typedef struct packed {
    logic [3:0] amp;
    logic       done;
  } exp_t;

  typedef struct {
    logic [3:0] inst;
    bit         note;
    logic [3:0] amp_a;
    bit         done_a;
    logic [3:0] amp_b;
    bit         done_b;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_ab, rst_c;
  logic        load, note_on, strobe;
  logic [3:0]  instrument;
  logic        valid_a, valid_b, valid_c;
  logic [3:0]  amp_a, amp_b, amp_c;
  logic        done_a, done_b, done_c;
  logic        busy_a, busy_b, busy_c;
  logic [7:0]  addr_a, addr_b, addr_c;
  logic [15:0] data_a, data_b, data_c;
  logic [7:0]  ra1, rb1, rc1, rc2, rc3;

  int n_checks = 0;
  int n_pass   = 0;
  exp_t qa[$], qb[$], qc[$];
  exp_t pa, pb, pc;
  vec_t vecs[9];

  always #5 clk = ~clk;

  envelope_sequencer #(.BASE_ADDRESS(8'h00), .ROM_LATENCY(1), .LOOP_ENABLE(1'b0)) dut_a (
    .i_clk(clk), .i_rst(rst_ab), .i_load_instrument(load), .i_instrument(instrument),
    .i_note_on(note_on), .i_strobe(strobe), .o_valid(valid_a), .o_amplitude(amp_a),
    .o_done(done_a), .o_busy(busy_a), .o_rom_addr(addr_a), .i_rom_data(data_a));

  envelope_sequencer #(.BASE_ADDRESS(8'h00), .ROM_LATENCY(1), .LOOP_ENABLE(1'b1)) dut_b (
    .i_clk(clk), .i_rst(rst_ab), .i_load_instrument(load), .i_instrument(instrument),
    .i_note_on(note_on), .i_strobe(strobe), .o_valid(valid_b), .o_amplitude(amp_b),
    .o_done(done_b), .o_busy(busy_b), .o_rom_addr(addr_b), .i_rom_data(data_b));

  envelope_sequencer #(.BASE_ADDRESS(8'h00), .ROM_LATENCY(3), .LOOP_ENABLE(1'b0)) dut_c (
    .i_clk(clk), .i_rst(rst_c), .i_load_instrument(load), .i_instrument(instrument),
    .i_note_on(note_on), .i_strobe(strobe), .o_valid(valid_c), .o_amplitude(amp_c),
    .o_done(done_c), .o_busy(busy_c), .o_rom_addr(addr_c), .i_rom_data(data_c));

  // ROM image: word 0/1 length nibbles, env words for instruments 2 (12), 3 (16), 5 (24).
  function automatic logic [15:0] rom_word(input logic [7:0] a);
    case (a)
      8'd0:    return 16'h1200;
      8'd1:    return 16'h0030;
      8'd12:   return 16'h0369;
      8'd16:   return 16'h0ED7;
      8'd24:   return 16'h000A;
      8'd25:   return 16'h00A0;
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge clk) begin
    ra1 <= addr_a;
    rb1 <= addr_b;
    rc1 <= addr_c;
    rc2 <= rc1;
    rc3 <= rc2;
  end
  assign data_a = rom_word(ra1);
  assign data_b = rom_word(rb1);
  assign data_c = rom_word(rc3);

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (valid_a) begin
      if (qa.size() == 0) check("a_unexpected_valid", 1, 0);
      else begin
        pa = qa.pop_front();
        check("a_amp", int'(amp_a), int'(pa.amp));
        check("a_done", int'(done_a), int'(pa.done));
      end
    end
    if (valid_b) begin
      if (qb.size() == 0) check("b_unexpected_valid", 1, 0);
      else begin
        pb = qb.pop_front();
        check("b_amp", int'(amp_b), int'(pb.amp));
        check("b_done", int'(done_b), int'(pb.done));
      end
    end
    if (valid_c) begin
      if (qc.size() == 0) check("c_unexpected_valid", 1, 0);
      else begin
        pc = qc.pop_front();
        check("c_amp", int'(amp_c), int'(pc.amp));
        check("c_done", int'(done_c), int'(pc.done));
      end
    end
  end

  // Load instrument, strobe, wait for the pulse; optional note-on with the strobe or during OUTPUT.
  task automatic run_strobe(input bit use_c, input logic [3:0] inst, input bit note_with,
                            input bit note_at_out, input int exp_lat, input exp_t ea, input exp_t eb);
    int lat;
    @(posedge clk); #1;
    load = 1'b1; instrument = inst;
    @(posedge clk); #1;
    load = 1'b0; strobe = 1'b1; note_on = note_with;
    if (use_c) qc.push_back(ea);
    else begin
      qa.push_back(ea);
      qb.push_back(eb);
    end
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      strobe = 1'b0; note_on = 1'b0;
      if (use_c ? valid_c : valid_a) begin
        lat = k;
        if (!use_c) check("b_valid_align", int'(valid_b), 1);
        if (note_at_out) note_on = 1'b1;
        break;
      end
    end
    check("latency", lat, exp_lat);
    @(posedge clk); #1;
    note_on = 1'b0;
  endtask

  initial begin
    int exp_addr36[5];
    int exp_addr39[9];
    int pulses;
    exp_addr36 = '{1, 0, 24, 0, 0};
    exp_addr39 = '{1, 1, 1, 0, 24, 24, 24, 0, 0};
    vecs[0] = '{4'd2, 1'b0, 4'h9, 1'b0, 4'h9, 1'b0};
    vecs[1] = '{4'd2, 1'b0, 4'h6, 1'b0, 4'h6, 1'b0};
    vecs[2] = '{4'd2, 1'b0, 4'h3, 1'b1, 4'h3, 1'b0};
    vecs[3] = '{4'd2, 1'b0, 4'h3, 1'b1, 4'h9, 1'b0};
    vecs[4] = '{4'd2, 1'b0, 4'h3, 1'b1, 4'h6, 1'b0};
    vecs[5] = '{4'd2, 1'b1, 4'h9, 1'b0, 4'h9, 1'b0};
    vecs[6] = '{4'd2, 1'b0, 4'h6, 1'b0, 4'h6, 1'b0};
    vecs[7] = '{4'd3, 1'b0, 4'hE, 1'b1, 4'hE, 1'b0};
    vecs[8] = '{4'd3, 1'b0, 4'hE, 1'b1, 4'h7, 1'b0};

    rst_ab = 1'b1; rst_c = 1'b1;
    load = 1'b0; note_on = 1'b0; strobe = 1'b0; instrument = 4'd0;
    repeat (3) @(posedge clk);
    #1 rst_ab = 1'b0;
    check("rst_valid", int'(valid_a), 0);
    check("rst_amp", int'(amp_a), 0);
    check("rst_done", int'(done_a), 0);
    check("rst_busy", int'(busy_a), 0);
    check("rst_busy_b", int'(busy_b), 0);
    check("rst_addr", int'(addr_a), 0);

    // Instrument 5: length word 1, envelope word 24, latency 5.
    @(posedge clk); #1;
    load = 1'b1; instrument = 4'd5;
    @(posedge clk); #1;
    load = 1'b0; strobe = 1'b1;
    qa.push_back({4'hA, 1'b0});
    qb.push_back({4'hA, 1'b0});
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      strobe = 1'b0;
      check("inst5_addr", int'(addr_a), exp_addr36[k-1]);
      check("inst5_valid", int'(valid_a), (k == 5) ? 1 : 0);
    end
    @(posedge clk); #1;
    check("amp_hold", int'(amp_a), 10);
    rst_ab = 1'b1;
    @(posedge clk); #1;
    rst_ab = 1'b0;

    for (int i = 0; i < 9; i++)
      run_strobe(1'b0, vecs[i].inst, vecs[i].note, 1'b0, 5,
                 {vecs[i].amp_a, vecs[i].done_a}, {vecs[i].amp_b, vecs[i].done_b});

    // Note-on coincident with OUTPUT at index 1.
    rst_ab = 1'b1;
    @(posedge clk); #1;
    rst_ab = 1'b0;
    run_strobe(1'b0, 4'd2, 1'b0, 1'b0, 5, {4'h9, 1'b0}, {4'h9, 1'b0});
    run_strobe(1'b0, 4'd2, 1'b0, 1'b1, 5, {4'h6, 1'b0}, {4'h6, 1'b0});
    run_strobe(1'b0, 4'd2, 1'b0, 1'b0, 5, {4'h9, 1'b0}, {4'h9, 1'b0});

    // Latency-3 instance: address hold and ignored second strobe.
    rst_ab = 1'b1; rst_c = 1'b0;
    @(posedge clk); #1;
    load = 1'b1; instrument = 4'd5;
    @(posedge clk); #1;
    load = 1'b0; strobe = 1'b1;
    qc.push_back({4'hA, 1'b0});
    pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      strobe = (k == 2);
      if (k <= 9) begin
        check("lat3_addr", int'(addr_c), exp_addr39[k-1]);
        check("lat3_valid", int'(valid_c), (k == 9) ? 1 : 0);
      end
      if (valid_c) pulses++;
    end
    check("lat3_pulses", pulses, 1);

    // Reset while in ENV_WAIT aborts the step.
    @(posedge clk); #1;
    strobe = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      strobe = 1'b0;
    end
    check("abort_pre_addr", int'(addr_c), 24);
    rst_c = 1'b1;
    @(posedge clk); #1;
    rst_c = 1'b0;
    check("abort_valid", int'(valid_c), 0);
    check("abort_amp", int'(amp_c), 0);
    check("abort_done", int'(done_c), 0);
    check("abort_busy", int'(busy_c), 0);
    check("abort_addr", int'(addr_c), 0);
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (valid_c) pulses++;
    end
    check("abort_no_pulse", pulses, 0);
    run_strobe(1'b1, 4'd5, 1'b0, 1'b0, 9, {4'hA, 1'b0}, {4'h0, 1'b0});

    repeat (3) @(posedge clk);
    check("qa_drained", qa.size(), 0);
    check("qb_drained", qb.size(), 0);
    check("qc_drained", qc.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
